// File: rtl/swire_pkg.sv
// Shared types and constants for the single-wire serial master.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package swire_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TURN,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_t;

  localparam logic [1:0] PULL_UP  = 2'b11;
  localparam logic [1:0] PULL_OFF = 2'b00;

  // Pull setting tied to the drive direction: pull off while driving, pull-up while released.
  function automatic logic [1:0] pull_for(input logic oen);
    return oen ? PULL_UP : PULL_OFF;
  endfunction

endpackage

// File: rtl/swire_sync.sv
// Two-flop synchronizer for the pad DOUT, mapping X/Z to 1 (pull-up idle level).
// Latency: 2 clk cycles from pad to sync_out.
// Backpressure: none; free-running every cycle.
module swire_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic sync_out
);

  logic din_clean;
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Only a solid 0 reads as low; anything unknown is treated as the idle-high wire.
  always_comb begin
    din_clean = (din === 1'b0) ? 1'b0 : 1'b1;
    meta_d    = din_clean;
    sync_d    = meta_q;
  end

  // Synchronizer flops, reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/swire_master.sv
// Half-duplex single-wire master: sends one frame, optionally turns the wire around and receives one.
// Latency: TX frame (DW+2)*CLK_DIV cycles from accept; RX result pulses one cycle after the stop-bit sample.
// Backpressure: tx_ready only in IDLE; tx_valid outside IDLE is dropped, nothing is queued.
module swire_master
  import swire_pkg::*;
#(
  parameter int CLK_DIV      = 8,
  parameter int DW           = 8,
  parameter int TURN_BITS    = 2,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          rx_en,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  output logic          rx_err,
  output logic          busy,
  output logic          DIN,
  output logic          OEN,
  output logic [1:0]    PULL,
  input  logic          DOUT
);

  localparam int CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IMAX   = (DW > TURN_BITS) ? DW : TURN_BITS;
  localparam int IW     = $clog2(IMAX) + 1;
  localparam int TO_CYC = TIMEOUT_BITS * CLK_DIV;
  localparam int TW     = $clog2(TO_CYC) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(CLK_DIV / 2);
  localparam logic [IW-1:0] DATA_LAST = IW'(DW - 1);
  localparam logic [IW-1:0] TURN_LAST = IW'(TURN_BITS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   bit_idx_q, bit_idx_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [DW-1:0]   tx_shift_q, tx_shift_d;
  logic            rx_en_q, rx_en_d;
  logic [DW-1:0]   rx_shift_q, rx_shift_d;
  logic            din_q, din_d;
  logic            oen_q, oen_d;
  logic [1:0]      pull_q, pull_d;
  logic            rx_valid_q, rx_valid_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_err_q, rx_err_d;

  logic            dout_s;
  logic            bit_end;
  logic            in_rx;

  swire_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .din      (DOUT),
    .sync_out (dout_s)
  );

  assign bit_end = (bit_cnt_q == CNT_LAST);
  assign in_rx   = (state_q == RX_WAIT) || (state_q == RX_START);

  // State register and all datapath flops; reset releases the wire immediately.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      to_cnt_q   <= '0;
      tx_shift_q <= '0;
      rx_en_q    <= 1'b0;
      rx_shift_q <= '0;
      din_q      <= 1'b1;
      oen_q      <= 1'b1;
      pull_q     <= PULL_UP;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      to_cnt_q   <= to_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_en_q    <= rx_en_d;
      rx_shift_q <= rx_shift_d;
      din_q      <= din_d;
      oen_q      <= oen_d;
      pull_q     <= pull_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Next-state logic: bit timing, TX shifting, turnaround, RX start detection and sampling.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    to_cnt_d   = to_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_en_d    = rx_en_q;
    rx_shift_d = rx_shift_q;

    // Timeout spans the whole wait including rejected start bits; it saturates so a
    // glitch that straddles expiry still times out on return to RX_WAIT.
    if (in_rx && (to_cnt_q != TO_LAST)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (tx_valid && tx_ready) begin
          state_d    = TX_START;
          tx_shift_d = tx_data;
          rx_en_d    = rx_en;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = rx_en_q ? TURN : IDLE;
        end
      end
      TURN: begin
        if (bit_end) begin
          if (bit_idx_q == TURN_LAST) begin
            state_d  = RX_WAIT;
            to_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      RX_WAIT: begin
        bit_cnt_d = '0;
        // A start bit seen in the expiry cycle takes priority over the timeout.
        if (!dout_s) begin
          state_d = RX_START;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end
      end
      RX_START: begin
        if (bit_cnt_q == CNT_MID) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = dout_s ? RX_WAIT : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          rx_shift_d = {dout_s, rx_shift_q[DW-1:1]};
          if (bit_idx_q == DATA_LAST) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: pad controls follow the upcoming state so they register in step with it.
  always_comb begin
    oen_d = 1'b1;
    din_d = 1'b1;
    unique case (state_d)
      TX_START: begin
        oen_d = 1'b0;
        din_d = 1'b0;
      end
      TX_DATA: begin
        oen_d = 1'b0;
        din_d = tx_shift_d[0];
      end
      TX_STOP: begin
        oen_d = 1'b0;
      end
      default: begin
        oen_d = 1'b1;
        din_d = 1'b1;
      end
    endcase
    pull_d = pull_for(oen_d);

    rx_valid_d = 1'b0;
    rx_err_d   = rx_err_q;
    rx_data_d  = rx_data_q;
    if ((state_q == RX_WAIT) && (state_d == IDLE)) begin
      rx_valid_d = 1'b1;
      rx_err_d   = 1'b1;
    end
    if ((state_q == RX_STOP) && (state_d == IDLE)) begin
      rx_valid_d = 1'b1;
      rx_err_d   = !dout_s;
      rx_data_d  = rx_shift_q;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign DIN      = din_q;
  assign OEN      = oen_q;
  assign PULL     = pull_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_swire_master.sv
// Bench for swire_master: pad cell plus responder model on the wire, with a transaction-level reference.
// Latency: checks frame timing in whole bit periods from the accept cycle.
// Backpressure: drives tx_valid only when tx_ready is expected high, plus one ignored request mid-frame.
module tb_swire_master;

  localparam int CLK_DIV      = 8;
  localparam int DW           = 8;
  localparam int TURN_BITS    = 2;
  localparam int TIMEOUT_BITS = 16;

  // Cycle numbers counted from the accept cycle (cycle 1 is the first after accept).
  localparam int TX_CYC   = (DW + 2) * CLK_DIV;
  localparam int RX_ENTRY = TX_CYC + TURN_BITS * CLK_DIV + 1;
  localparam int TO_AT    = RX_ENTRY + TIMEOUT_BITS * CLK_DIV;
  localparam int RUN_TX   = TX_CYC + 20;
  localparam int RUN_RX   = TO_AT + 35;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic          rx_en = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_err;
  logic          busy;
  logic          DIN;
  logic          OEN;
  logic [1:0]    PULL;
  logic          DOUT;

  logic          resp_oe = 1'b0;
  logic          resp_val = 1'b1;

  int            n_checks = 0;
  int            n_fail = 0;
  int            pull_viol = 0;
  int            conflict = 0;
  logic [DW-1:0] exp_rx_data = '0;

  swire_master #(
    .CLK_DIV      (CLK_DIV),
    .DW           (DW),
    .TURN_BITS    (TURN_BITS),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_en    (rx_en),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .busy     (busy),
    .DIN      (DIN),
    .OEN      (OEN),
    .PULL     (PULL),
    .DOUT     (DOUT)
  );

  always #5 clk = ~clk;

  // Pad cell: master drive wins, then responder, then the pull; an unpulled released wire floats.
  assign DOUT = !OEN ? DIN : (resp_oe ? resp_val : (PULL[1] ? PULL[0] : 1'bx));

  // Wire-level rules that must hold in every cycle out of reset.
  always @(negedge clk) begin
    if (rstn) begin
      if ((!OEN && PULL !== 2'b00) || (OEN && PULL !== 2'b11)) pull_viol++;
      if (!OEN && resp_oe) conflict++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. Call at a negedge with the DUT idle; returns at a negedge.
  // mode: 0 silent responder, 1 frame, 2 two-cycle low glitch then frame.
  task automatic run_txn(input logic [DW-1:0] data, input bit ren, input int mode,
                         input logic [DW-1:0] rdata, input bit rstop,
                         input int gdly, input int fdly);
    int         g, s, k, last_c, n_pulse, pulse_c, first_low, last_low, n_low;
    logic [9:0] obs, expb;
    logic [DW-1:0] got_d;
    logic       got_e, exp_e;
    g = RX_ENTRY + gdly;
    s = (mode == 2) ? (g + 20 + fdly) : (RX_ENTRY + fdly);
    last_c = ren ? RUN_RX : RUN_TX;
    n_pulse = 0; pulse_c = -1; first_low = -1; last_low = -1; n_low = 0;
    obs = '0; got_d = '0; got_e = 1'b0;

    tx_valid = 1'b1;
    tx_data  = data;
    rx_en    = ren;
    chk("ready_pre", {31'd0, tx_ready}, 1);
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
        rx_en    = 1'($urandom_range(0, 1));
      end
      if (c == 40) begin
        chk("busy_mid", {31'd0, busy}, 1);
        tx_valid = 1'b1;
      end
      if (c == 41) tx_valid = 1'b0;

      if (!OEN) begin
        n_low++;
        if (first_low < 0) first_low = c;
        last_low = c;
      end
      if ((c % CLK_DIV == CLK_DIV / 2) && (c <= TX_CYC)) obs[(c - 1) / CLK_DIV] = DIN;
      if (rx_valid) begin
        n_pulse++;
        pulse_c = c;
        got_d = rx_data;
        got_e = rx_err;
        chk("ready_w_valid", {31'd0, tx_ready}, 1);
      end

      resp_oe  = 1'b0;
      resp_val = 1'b1;
      if (ren && mode == 2 && (c == g || c == g + 1)) begin
        resp_oe  = 1'b1;
        resp_val = 1'b0;
      end
      if (ren && mode != 0 && c >= s && c < s + (DW + 2) * CLK_DIV) begin
        k = (c - s) / CLK_DIV;
        resp_oe  = 1'b1;
        resp_val = (k == 0) ? 1'b0 : (k == DW + 1) ? rstop : rdata[k - 1];
      end
    end
    resp_oe = 1'b0;

    expb = {1'b1, data, 1'b0};
    chk("tx_frame", {22'd0, obs}, {22'd0, expb});
    chk("oen_first", first_low, 1);
    chk("oen_last", last_low, TX_CYC);
    chk("oen_cnt", n_low, TX_CYC);
    chk("pulses", n_pulse, ren ? 1 : 0);
    if (ren && n_pulse == 1) begin
      if (mode == 0) begin
        exp_e = 1'b1;
        chk("to_cycle", pulse_c, TO_AT);
      end else begin
        exp_rx_data = rdata;
        exp_e = !rstop;
      end
      chk("rx_data", {24'd0, got_d}, {24'd0, exp_rx_data});
      chk("rx_err", {31'd0, got_e}, {31'd0, exp_e});
    end
    chk("ready_end", {31'd0, tx_ready}, 1);
    chk("busy_end", {31'd0, busy}, 0);
  endtask

  initial begin
    int mode;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oen", {31'd0, OEN}, 1);
    chk("rst_din", {31'd0, DIN}, 1);
    chk("rst_pull", {30'd0, PULL}, 3);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_err", {31'd0, rx_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, tx_ready}, 1);
    rstn = 1'b1;

    run_txn(8'hA5, 1'b0, 0, 8'h00, 1'b1, 0, 0);
    run_txn(8'h12, 1'b1, 1, 8'h3C, 1'b1, 0, 0);
    run_txn(8'h6E, 1'b1, 0, 8'h00, 1'b1, 0, 0);
    run_txn(8'hC3, 1'b1, 1, 8'h81, 1'b0, 0, 5);
    run_txn(8'h0F, 1'b1, 2, 8'h55, 1'b1, 3, 4);

    // Reset pulse in the middle of the data bits.
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    rx_en    = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (29) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_oen", {31'd0, OEN}, 1);
    chk("mid_rst_din", {31'd0, DIN}, 1);
    chk("mid_rst_pull", {30'd0, PULL}, 3);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ready", {31'd0, tx_ready}, 1);
    chk("mid_rst_rx_valid", {31'd0, rx_valid}, 0);
    rstn = 1'b1;
    exp_rx_data = '0;
    run_txn(8'h5A, 1'b1, 0, 8'h00, 1'b1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      mode = int'($urandom_range(0, 2));
      run_txn(DW'($urandom), 1'($urandom_range(0, 1)), mode, DW'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, (mode == 1) ? 60 : 20)));
    end

    chk("pull_rule", pull_viol, 0);
    chk("bus_conflict", conflict, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
